// File: rtl/clock_gen_pkg.sv
// -----------------------------------------------------------------------------
// clock_gen_pkg
// Shared constants and elaboration-time helpers for the clock_gen block.
//   DEF_PERIOD / DEF_CNT_W / DEF_MAX_CYCLES : default parameter values
//   clamp_period(p)   : period with the lower bound of 2 applied
//   low_phase(p)      : number of low phases per derived period (floor(P/2))
//   ph_width(p)       : bit width of the phase counter for the clamped period
//   max_reachable(m,w): whether a w-bit counter can ever hold the value m
// -----------------------------------------------------------------------------
package clock_gen_pkg;

  localparam int DEF_PERIOD     = 10;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_MAX_CYCLES = 100;

  function automatic int clamp_period(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int low_phase(input int p);
    return clamp_period(p) / 2;
  endfunction

  function automatic int ph_width(input int p);
    return $clog2(clamp_period(p));
  endfunction

  // A target beyond the counter's saturation value can never be reached, so
  // done must never assert in that case (the truncated compare would lie).
  function automatic bit max_reachable(input int max_cycles, input int cnt_w);
    if (cnt_w >= 31) return 1'b1;
    return max_cycles <= ((1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/clock_gen_phase_ctr.sv
// -----------------------------------------------------------------------------
// clock_gen_phase_ctr
// Wrapping phase counter 0..P-1 (P = clamped PERIOD) with run enable and a
// synchronous clear. The next-phase value is exported so the parent can
// register its outputs from the same value the counter is about to load.
//   clk     : system clock
//   reset   : asynchronous, active-high reset (phase -> 0)
//   en      : advance/load enable; phase holds when low
//   clr     : force the next phase to 0 (used to park the counter)
//   ph_next : phase value that will be loaded on the next enabled edge
// -----------------------------------------------------------------------------
module clock_gen_phase_ctr
  import clock_gen_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int W      = ph_width(PERIOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] ph_next
);

  localparam int         P    = clamp_period(PERIOD);
  localparam logic [W-1:0] LAST = W'(P - 1);

  logic [W-1:0] ph;

  always_comb begin
    ph_next = '0;
    if (clr)
      ph_next = '0;
    else if (ph == LAST)
      ph_next = '0;
    else
      ph_next = ph + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ph <= '0;
    else if (en)
      ph <= ph_next;
  end

endmodule

// File: rtl/clock_gen.sv
// -----------------------------------------------------------------------------
// clock_gen
// Derived-clock generator and run-length limiter. clk_out has a period of
// max(PERIOD,2) clk cycles: low for floor(P/2) phases, high for the rest.
// rise/fall are one-clk strobes aligned with the registered clk_out edges,
// cycle_cnt counts clk_out rising edges (saturating), and done is a sticky
// flag set when cycle_cnt reaches MAX_CYCLES.
//
// Optional feature macro: CLOCK_GEN_STOP_EN
//   defined   : once done is set, clk_out is parked low (one final fall strobe
//               if it was high), the phase counter parks at 0 and cycle_cnt
//               freezes.
//   undefined : clk_out keeps running after done.
//
// Ports
//   clk       : system clock, all state updates on posedge
//   reset     : asynchronous, active-high reset
//   en        : run enable; when low all state holds and strobes are 0
//   clk_out   : derived clock (registered, glitch-free)
//   rise      : one-clk pulse coincident with clk_out 0->1
//   fall      : one-clk pulse coincident with clk_out 1->0
//   cycle_cnt : clk_out rising edges since reset, saturates at all-ones
//   done      : sticky, set when cycle_cnt reaches MAX_CYCLES
// -----------------------------------------------------------------------------
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             clk_out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done
);

  localparam int               W       = ph_width(PERIOD);
  localparam logic [W-1:0]     LOW     = W'(low_phase(PERIOD));
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CYCLES);
  localparam bit               MAX_OK  = max_reachable(MAX_CYCLES, CNT_W);
  localparam bit               MAX_ZERO = (MAX_CYCLES == 0);

  logic             stop;
  logic [W-1:0]     ph_next;
  logic             out_next;
  logic             rise_next;
  logic             fall_next;
  logic [CNT_W-1:0] cnt_next;
  logic             done_hit;

`ifdef CLOCK_GEN_STOP_EN
  assign stop = done;
`else
  assign stop = 1'b0;
`endif

  clock_gen_phase_ctr #(
    .PERIOD (PERIOD),
    .W      (W)
  ) u_phase_ctr (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (stop),
    .ph_next (ph_next)
  );

  // While stopped the counter is parked at 0, which would otherwise read as a
  // fall every edge; the only fall allowed is the one taking clk_out low.
  always_comb begin
    out_next  = 1'b0;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (stop) begin
      fall_next = clk_out;
    end else begin
      out_next  = (ph_next >= LOW);
      rise_next = (ph_next == LOW);
      fall_next = (ph_next == '0);
    end
  end

  always_comb begin
    cnt_next = cycle_cnt;
    if (rise_next && (cycle_cnt != CNT_SAT))
      cnt_next = cycle_cnt + CNT_W'(1);
  end

  // MAX_CYCLES of 0 is met by the very first enabled edge regardless of count.
  assign done_hit = MAX_ZERO || (MAX_OK && (cnt_next == MAX_VAL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_out   <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      cycle_cnt <= '0;
      done      <= 1'b0;
    end else if (en) begin
      clk_out   <= out_next;
      rise      <= rise_next;
      fall      <= fall_next;
      cycle_cnt <= cnt_next;
      done      <= done | done_hit;
    end else begin
      rise      <= 1'b0;
      fall      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_gen.sv
module tb_clock_gen;

  localparam int N = 4;

`ifdef CLOCK_GEN_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic en;

  always #5 clk = ~clk;

  logic        co0, ri0, fa0, dn0;
  logic [31:0] cc0;
  logic        co1, ri1, fa1, dn1;
  logic [7:0]  cc1;
  logic        co2, ri2, fa2, dn2;
  logic [7:0]  cc2;
  logic        co3, ri3, fa3, dn3;
  logic [2:0]  cc3;

  clock_gen #(.PERIOD(10), .CNT_W(32), .MAX_CYCLES(4)) u0 (
    .clk(clk), .reset(reset), .en(en), .clk_out(co0), .rise(ri0),
    .fall(fa0), .cycle_cnt(cc0), .done(dn0));
  clock_gen #(.PERIOD(3), .CNT_W(8), .MAX_CYCLES(100)) u1 (
    .clk(clk), .reset(reset), .en(en), .clk_out(co1), .rise(ri1),
    .fall(fa1), .cycle_cnt(cc1), .done(dn1));
  clock_gen #(.PERIOD(1), .CNT_W(8), .MAX_CYCLES(0)) u2 (
    .clk(clk), .reset(reset), .en(en), .clk_out(co2), .rise(ri2),
    .fall(fa2), .cycle_cnt(cc2), .done(dn2));
  clock_gen #(.PERIOD(2), .CNT_W(3), .MAX_CYCLES(100)) u3 (
    .clk(clk), .reset(reset), .en(en), .clk_out(co3), .rise(ri3),
    .fall(fa3), .cycle_cnt(cc3), .done(dn3));

  // Reference model: position within the derived period is simply the number
  // of enabled edges since reset modulo P; the clock is high in the upper half.
  int     per_m [N];
  int     max_m [N];
  longint sat_m [N];
  int     edges_m [N];
  longint cnt_m [N];
  bit     out_m [N];
  bit     rise_m [N];
  bit     fall_m [N];
  bit     done_m [N];
  bit     stopped_m [N];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_init();
    int req [N] = '{10, 3, 1, 2};
    int mx  [N] = '{4, 100, 0, 100};
    int w   [N] = '{32, 8, 8, 3};
    for (int i = 0; i < N; i++) begin
      per_m[i] = (req[i] < 2) ? 2 : req[i];
      max_m[i] = mx[i];
      sat_m[i] = (64'sd1 <<< w[i]) - 1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      edges_m[i]   = 0;
      cnt_m[i]     = 0;
      out_m[i]     = 1'b0;
      rise_m[i]    = 1'b0;
      fall_m[i]    = 1'b0;
      done_m[i]    = 1'b0;
      stopped_m[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit e);
    for (int i = 0; i < N; i++) begin
      int pos;
      int low;
      bit was_high;
      rise_m[i] = 1'b0;
      fall_m[i] = 1'b0;
      if (e) begin
        if (STOP && done_m[i]) stopped_m[i] = 1'b1;
        if (stopped_m[i]) begin
          fall_m[i] = out_m[i];
          out_m[i]  = 1'b0;
        end else begin
          was_high   = out_m[i];
          edges_m[i] = edges_m[i] + 1;
          low        = per_m[i] / 2;
          pos        = edges_m[i] % per_m[i];
          out_m[i]   = (pos >= low);
          rise_m[i]  = out_m[i] && !was_high;
          fall_m[i]  = !out_m[i] && was_high;
          if (rise_m[i] && cnt_m[i] < sat_m[i]) cnt_m[i] = cnt_m[i] + 1;
          if (max_m[i] == 0 || cnt_m[i] == max_m[i]) done_m[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    bit     o_co, o_ri, o_fa, o_dn;
    longint o_cc;
    for (int i = 0; i < N; i++) begin
      case (i)
        0: begin o_co = co0; o_ri = ri0; o_fa = fa0; o_dn = dn0; o_cc = longint'(cc0); end
        1: begin o_co = co1; o_ri = ri1; o_fa = fa1; o_dn = dn1; o_cc = longint'(cc1); end
        2: begin o_co = co2; o_ri = ri2; o_fa = fa2; o_dn = dn2; o_cc = longint'(cc2); end
        default: begin o_co = co3; o_ri = ri3; o_fa = fa3; o_dn = dn3; o_cc = longint'(cc3); end
      endcase
      check($sformatf("u%0d.clk_out", i),   longint'(o_co), longint'(out_m[i]));
      check($sformatf("u%0d.rise", i),      longint'(o_ri), longint'(rise_m[i]));
      check($sformatf("u%0d.fall", i),      longint'(o_fa), longint'(fall_m[i]));
      check($sformatf("u%0d.cycle_cnt", i), o_cc,           cnt_m[i]);
      check($sformatf("u%0d.done", i),      longint'(o_dn), longint'(done_m[i]));
    end
  endtask

  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    model_edge(e);
    #1;
    check_all();
  endtask

  // Reset asserted between edges must clear everything with no clk edge.
  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_init();
    model_reset();
    reset = 1'b1;
    en    = 1'b0;
    #2;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Run until u0 is in its high phase, then reset mid-period.
    repeat (7) step(1'b1);
    check("u0.high_before_reset", longint'(co0), 1);
    async_reset();

    // Advance to phase 3, hold for 7 edges, then run past done on u0.
    repeat (3) step(1'b1);
    repeat (7) step(1'b0);
    repeat (50) step(1'b1);

    // Randomized enable pattern with occasional mid-period resets.
    repeat (700) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      step($urandom_range(0, 99) < 80);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
